// File: rtl/mcu_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, function codes,
// ALU operations, next-PC selects, FSM states and decoded instruction classes.
package mcu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b000001;
  localparam logic [5:0] OP_ANDI  = 6'b001001;
  localparam logic [5:0] OP_ORI   = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b001101;
  localparam logic [5:0] OP_SW    = 6'b001110;
  localparam logic [5:0] OP_BEQ   = 6'b001111;
  localparam logic [5:0] OP_BNE   = 6'b010000;
  localparam logic [5:0] OP_J     = 6'b010010;

  localparam logic [5:0] FN_ADD = 6'b000001;
  localparam logic [5:0] FN_SUB = 6'b000010;
  localparam logic [5:0] FN_AND = 6'b000011;
  localparam logic [5:0] FN_OR  = 6'b000100;
  localparam logic [5:0] FN_SLL = 6'b000101;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b11;

  localparam logic [2:0] ST_IF  = 3'd0;
  localparam logic [2:0] ST_ID  = 3'd1;
  localparam logic [2:0] ST_EX  = 3'd2;
  localparam logic [2:0] ST_MEM = 3'd3;
  localparam logic [2:0] ST_WB  = 3'd4;

  typedef enum logic [2:0] {
    S_IF  = ST_IF,
    S_ID  = ST_ID,
    S_EX  = ST_EX,
    S_MEM = ST_MEM,
    S_WB  = ST_WB
  } state_t;

  typedef enum logic [2:0] {
    IC_ALU,
    IC_LOAD,
    IC_STORE,
    IC_BEQ,
    IC_BNE,
    IC_JUMP,
    IC_NONE
  } iclass_t;

endpackage

// File: rtl/mcu_decoder.sv
// Combinational instruction decoder: opcode/function -> instruction class and
// EX/WB datapath controls; flags anything outside the defined instruction set.
module mcu_decoder
  import mcu_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int FUNC_W = 6
) (
  input  logic [OP_W-1:0]   i_op,
  input  logic [FUNC_W-1:0] i_func,
  output iclass_t           o_iclass,
  output logic [2:0]        o_aluc,
  output logic              o_sext,
  output logic              o_aluimm,
  output logic              o_shift,
  output logic              o_regrt,
  output logic              o_illegal
);

  always_comb begin
    o_iclass  = IC_NONE;
    o_aluc    = ALU_ADD;
    o_sext    = 1'b0;
    o_aluimm  = 1'b0;
    o_shift   = 1'b0;
    o_regrt   = 1'b0;
    o_illegal = 1'b0;
    case (i_op)
      OP_W'(OP_RTYPE): begin
        o_iclass = IC_ALU;
        case (i_func)
          FUNC_W'(FN_ADD): o_aluc = ALU_ADD;
          FUNC_W'(FN_SUB): o_aluc = ALU_SUB;
          FUNC_W'(FN_AND): o_aluc = ALU_AND;
          FUNC_W'(FN_OR):  o_aluc = ALU_OR;
          FUNC_W'(FN_SLL): begin
            o_aluc  = ALU_SLL;
            o_shift = 1'b1;
          end
          default: begin
            o_iclass  = IC_NONE;
            o_illegal = 1'b1;
          end
        endcase
      end
      OP_W'(OP_ADDI): begin
        o_iclass = IC_ALU;
        o_aluimm = 1'b1;
        o_sext   = 1'b1;
        o_regrt  = 1'b1;
      end
      OP_W'(OP_ANDI): begin
        o_iclass = IC_ALU;
        o_aluc   = ALU_AND;
        o_aluimm = 1'b1;
        o_regrt  = 1'b1;
      end
      OP_W'(OP_ORI): begin
        o_iclass = IC_ALU;
        o_aluc   = ALU_OR;
        o_aluimm = 1'b1;
        o_regrt  = 1'b1;
      end
      OP_W'(OP_LW): begin
        o_iclass = IC_LOAD;
        o_aluimm = 1'b1;
        o_sext   = 1'b1;
        o_regrt  = 1'b1;
      end
      OP_W'(OP_SW): begin
        o_iclass = IC_STORE;
        o_aluimm = 1'b1;
        o_sext   = 1'b1;
      end
      // Branches drive a subtract so the ALU mirrors the rs/rt compare.
      OP_W'(OP_BEQ): begin
        o_iclass = IC_BEQ;
        o_aluc   = ALU_SUB;
        o_sext   = 1'b1;
      end
      OP_W'(OP_BNE): begin
        o_iclass = IC_BNE;
        o_aluc   = ALU_SUB;
        o_sext   = 1'b1;
      end
      OP_W'(OP_J): o_iclass = IC_JUMP;
      default:     o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle instruction-sequencing FSM with memory handshake and a
// retired-instruction counter; decoding is delegated to mcu_decoder.
//
// state | meaning
// IF    | request instruction fetch; load IR and PC+4 on mem_ready
// ID    | decode; undefined instruction pulses illegal and refetches
// EX    | ALU controls; branches and jumps resolve and retire here
// MEM   | load/store access, held until mem_ready
// WB    | register write-back, then retire
module multicycle_control_unit
  import mcu_pkg::*;
#(
  parameter int OP_W   = 6,
  parameter int FUNC_W = 6,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [OP_W-1:0]   op,
  input  logic [FUNC_W-1:0] func,
  input  logic              rsrtequ,
  input  logic              mem_ready,
  output logic              mem_req,
  output logic              irwrite,
  output logic              pcwrite,
  output logic              wreg,
  output logic              m2reg,
  output logic              wmem,
  output logic              regrt,
  output logic              aluimm,
  output logic              sext,
  output logic              shift,
  output logic [2:0]        aluc,
  output logic [1:0]        pcsource,
  output logic [2:0]        state,
  output logic              illegal,
  output logic [CNT_W-1:0]  retired
);

  state_t           r_state;
  state_t           w_next;
  logic             r_quiet;
  logic [CNT_W-1:0] r_retired;
  logic             w_retire;
  logic             w_taken;

  iclass_t    w_iclass;
  logic [2:0] w_aluc;
  logic       w_sext;
  logic       w_aluimm;
  logic       w_shift;
  logic       w_regrt;
  logic       w_illegal;

  mcu_decoder #(
    .OP_W   (OP_W),
    .FUNC_W (FUNC_W)
  ) u_decoder (
    .i_op      (op),
    .i_func    (func),
    .o_iclass  (w_iclass),
    .o_aluc    (w_aluc),
    .o_sext    (w_sext),
    .o_aluimm  (w_aluimm),
    .o_shift   (w_shift),
    .o_regrt   (w_regrt),
    .o_illegal (w_illegal)
  );

  // r_quiet keeps every control low for the cycle following a reset edge,
  // so a fetch request cannot appear before the unit has settled in IF.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IF;
      r_quiet   <= 1'b1;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_quiet <= 1'b0;
      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign w_taken = (w_iclass == IC_BEQ) ? rsrtequ : ~rsrtequ;

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    mem_req  = 1'b0;
    irwrite  = 1'b0;
    pcwrite  = 1'b0;
    wreg     = 1'b0;
    m2reg    = 1'b0;
    wmem     = 1'b0;
    regrt    = 1'b0;
    aluimm   = 1'b0;
    sext     = 1'b0;
    shift    = 1'b0;
    aluc     = ALU_ADD;
    pcsource = PC_SEQ;
    illegal  = 1'b0;
    if (r_quiet) begin
      w_next = S_IF;
    end else begin
      case (r_state)
        S_IF: begin
          mem_req = 1'b1;
          if (mem_ready) begin
            irwrite = 1'b1;
            pcwrite = 1'b1;
            w_next  = S_ID;
          end
        end
        S_ID: begin
          if (w_illegal) begin
            illegal = 1'b1;
            w_next  = S_IF;
          end else begin
            w_next = S_EX;
          end
        end
        S_EX: begin
          aluc   = w_aluc;
          aluimm = w_aluimm;
          sext   = w_sext;
          shift  = w_shift;
          case (w_iclass)
            IC_BEQ, IC_BNE: begin
              if (w_taken) begin
                pcwrite  = 1'b1;
                pcsource = PC_BRANCH;
              end
              w_retire = 1'b1;
              w_next   = S_IF;
            end
            IC_JUMP: begin
              pcwrite  = 1'b1;
              pcsource = PC_JUMP;
              w_retire = 1'b1;
              w_next   = S_IF;
            end
            IC_LOAD, IC_STORE: w_next = S_MEM;
            IC_ALU:            w_next = S_WB;
            default:           w_next = S_IF;
          endcase
        end
        S_MEM: begin
          mem_req = 1'b1;
          wmem    = (w_iclass == IC_STORE);
          if (mem_ready) begin
            if (w_iclass == IC_STORE) begin
              w_retire = 1'b1;
              w_next   = S_IF;
            end else begin
              w_next = S_WB;
            end
          end
        end
        S_WB: begin
          wreg     = 1'b1;
          m2reg    = (w_iclass == IC_LOAD);
          regrt    = w_regrt;
          w_retire = 1'b1;
          w_next   = S_IF;
        end
        default: w_next = S_IF;
      endcase
    end
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter OP_W, default 6, opcode field width.
REQ-002 Parameter FUNC_W, default 6, function field width.
REQ-003 Parameter CNT_W, default 32, retired-instruction counter width.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset, with ports as listed below.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous, active-high reset.
REQ-007 op  in  OP_W  opcode of the instruction register.
REQ-008 func  in  FUNC_W  R-type function code.
REQ-009 rsrtequ  in  1  rs==rt comparison.
REQ-010 mem_ready  in  1  memory handshake done, valid while mem_req=1.
REQ-011 mem_req  out  1  memory access request, held until mem_ready.
REQ-012 irwrite, pcwrite  out  1 each  load the IR / update the PC this cycle.
REQ-013 wreg, m2reg, wmem, regrt, aluimm, sext, shift  out  1 each  datapath controls.
REQ-014 aluc  out  3  ALU op; pcsource  out  2  next-PC select.
REQ-015 state  out  3  current FSM state; illegal  out  1  undefined-opcode pulse.
REQ-016 retired  out  CNT_W  count of completed instructions.

Function
REQ-017 Opcodes SHALL be: R-type 000000, addi 000001, andi 001001, ori 001010, lw 001101, sw 001110, beq 001111, bne 010000, j 010010.
REQ-018 R-type func codes SHALL be: add 000001, sub 000010, and 000011, or 000100, sll 000101.
REQ-019 aluc SHALL be: 000 add, 001 sub, 010 and, 011 or, 100 sll.
REQ-020 pcsource SHALL be: 00 PC+4, 01 branch target, 11 jump target.
REQ-021 FSM states SHALL be IF=0, ID=1, EX=2, MEM=3, WB=4.
REQ-022 IF: mem_req=1. On mem_ready: irwrite=1, pcwrite=1, pcsource=00, go to ID. Otherwise stay in IF.
REQ-023 ID: decode only. An undefined op or func SHALL pulse illegal for 1 cycle and go to IF with no writes.
REQ-024 EX: assert aluc/aluimm/sext/shift per opcode.
REQ-025 EX for beq/bne: compare using rsrtequ. beq taken when rsrtequ=1; bne taken when rsrtequ=0. Taken: pcwrite=1, pcsource=01. Then go to IF.
REQ-026 EX for j: pcwrite=1, pcsource=11, then go to IF.
REQ-027 EX for lw/sw: go to MEM. EX for R-type and immediate ops: go to WB.
REQ-028 MEM: mem_req=1. wmem=1 for sw only, asserted while mem_req=1. On mem_ready: sw goes to IF, lw goes to WB. Otherwise hold every output.
REQ-029 WB: wreg=1 for one cycle; m2reg=1 for lw only; regrt=1 for I-type. Then go to IF.
REQ-030 sext SHALL be 1 for addi, lw, sw, beq, bne and 0 for andi and ori. shift SHALL be 1 for sll only.
REQ-031 retired SHALL increment by 1 on the cycle an instruction leaves its final state (WB; MEM for sw; EX for branch/j). It SHALL wrap to 0 from all-ones. Illegal instructions SHALL NOT count.
REQ-032 Outputs not listed as asserted for a state SHALL be 0, except aluc=000 and pcsource=00.
REQ-033 Latency with mem_ready tied high SHALL be: branch/j 3 cycles, sw 4, R-type/immediate 4, lw 5.

Reset
REQ-034 When rst=1 at a clock edge: state=IF, retired=0, and every control output 0 on the next cycle. This holds in any state, including mid-handshake.
REQ-035 A mem_ready arriving in the same cycle as rst SHALL be ignored.

Structure
REQ-036 Opcode, func, aluc, pcsource and state encodings SHALL be localparams in shared package mcu_pkg.
REQ-037 Decoding SHALL be a combinational sub-module mcu_decoder (op, func -> instruction class, aluc, sext, aluimm, shift, regrt, illegal). The FSM and counter SHALL stay in the top.

Verification
REQ-038 add: op=000000, func=000001, mem_ready=1 -> states IF,ID,EX,WB; wreg=1 in WB with aluc=000, regrt=0; retired +1.
REQ-039 lw: op=001101 with mem_ready low 3 cycles in MEM -> stays in MEM with mem_req=1 and wmem=0, then WB with m2reg=1, wreg=1.
REQ-040 beq: op=001111, rsrtequ=1 -> pcwrite=1, pcsource=01 in EX. Repeat with rsrtequ=0 -> pcwrite=0 in EX.
REQ-041 bne: op=010000, rsrtequ=0 -> taken. Then j: op=010010 -> pcsource=11 in EX.
REQ-042 illegal: op=111111 -> illegal=1 for 1 cycle in ID, no wreg/wmem, retired unchanged. Counter preloaded to all-ones plus one retire -> 0.
REQ-043 rst=1 during MEM of sw -> next cycle state=IF, wmem=0, retired=0.
